// File: rtl/sobel_uart_tx.sv
// sobel_uart_tx: elastic FIFO between the Sobel filter and an 8N1 UART transmitter.
// Reports backlog (fifo_count) and sticky byte loss (overflow).
// Optional: define SOBEL_UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
module sobel_uart_tx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 2048
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

`ifdef SOBEL_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_d;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  state_t               state;
  state_t               state_d;
  logic [BW-1:0]        baud;
  logic [BW-1:0]        baud_d;
  logic [IW-1:0]        bit_idx;
  logic [IW-1:0]        bit_idx_d;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_d;
  logic                 baud_last;
  logic                 tx_d;

  // Full is judged on the registered count, before any same-cycle pop.
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign empty     = (fifo_count == '0);
  assign push      = valid_in && !full;
  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = fifo_count;
    if (push && !pop) begin
      count_d = fifo_count + CW'(1);
    end else if (pop && !push) begin
      count_d = fifo_count - CW'(1);
    end
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, count, ready and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready_in   <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_d;
      ready_in   <= (count_d != CW'(FIFO_DEPTH));
      if (valid_in && full) overflow <= 1'b1;
    end
  end

  // TX state register; tx and tx_busy are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
      tx_busy <= (state_d != IDLE);
    end
  end

  // TX next-state: frames pop the FIFO head and chain without an idle gap.
  always_comb begin
    state_d   = state;
    baud_d    = baud_last ? '0 : baud + BW'(1);
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    pop       = 1'b0;
    tx_d      = 1'b1;

    case (state)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          shreg_d   = mem[rd_ptr];
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        if (baud_last) begin
          if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef SOBEL_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + IW'(1);
          end
        end
      end
`ifdef SOBEL_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_last) begin
          if (!empty) begin
            pop       = 1'b1;
            shreg_d   = mem[rd_ptr];
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bit_idx_d];
`ifdef SOBEL_UART_TX_PARITY_EN
      PARITY:  tx_d = ^shreg_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sobel_uart_tx.sv
// Scoreboard bench for sobel_uart_tx: a frame-level model predicts FIFO
// occupancy, line level and transmitted bytes; a UART monitor decodes tx.
module tb_sobel_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
`ifdef SOBEL_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * C;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       overflow;

  sobel_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .tx(tx), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int next_pop = 0;
  int cur_start = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic ovf_m = 1'b0;
  int rst_cnt = 0;

  always @(negedge rst) rst_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  // Model: a frame pops the head when the line is free; each frame lasts F cycles.
  function automatic void model_edge(input logic v, input logic [7:0] d);
    bit was_full;
    was_full = (q.size() == D);
    if (q.size() > 0 && edge_n >= next_pop) begin
      cur_byte  = q.pop_front();
      exp_q.push_back(cur_byte);
      cur_start = edge_n;
      next_pop  = edge_n + F;
    end
    if (v) begin
      if (was_full) ovf_m = 1'b1;
      else q.push_back(d);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    exp_q.delete();
    ovf_m    = 1'b0;
    next_pop = 0;
  endfunction

  // Expected line level from the position within the current frame.
  function automatic logic exp_tx();
    int pos;
    int b;
    if (edge_n >= next_pop) return 1'b1;
    pos = edge_n - cur_start;
    b   = pos / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur_byte[b-1];
`ifdef SOBEL_UART_TX_PARITY_EN
    if (b == 9) return ^cur_byte;
`endif
    return 1'b1;
  endfunction

  task automatic check_regs();
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("ready_in", 32'(ready_in), 32'(q.size() != D));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("tx_busy", 32'(tx_busy), 32'(edge_n < next_pop));
    chk("tx", 32'(tx), 32'(exp_tx()));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    edge_n++;
    if (rst) model_edge(v, d);
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Asynchronous reset pulse, checked immediately after assertion.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    idle(2);
    rst = 1'b1;
  endtask

  // UART monitor: samples each bit mid-cell and scores against the expected queue.
  logic [7:0] m_byte;
  logic       m_start;
  logic       m_stop;
  logic       m_par;
  int         m_rst0;
  initial begin
    m_par = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        m_rst0 = rst_cnt;
        repeat (C / 2) @(negedge clk);
        m_start = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          m_byte[i] = tx;
        end
`ifdef SOBEL_UART_TX_PARITY_EN
        repeat (C) @(negedge clk);
        m_par = tx;
`endif
        repeat (C) @(negedge clk);
        m_stop = tx;
        if (m_rst0 == rst_cnt && rst === 1'b1) begin
          chk("start_bit", 32'(m_start), 32'd0);
          chk("stop_bit", 32'(m_stop), 32'd1);
`ifdef SOBEL_UART_TX_PARITY_EN
          chk("parity_bit", 32'(m_par), 32'(^m_byte));
`endif
          if (exp_q.size() == 0) chk("unexpected_frame", 32'(m_byte), 32'hFFFF_FFFF);
          else chk("rx_byte", 32'(m_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    valid_in = 1'b0;
    data_in  = 8'h00;
    rst      = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b1;
    idle(2);

    // Single byte.
    step(1'b1, 8'hA5);
    idle(F + 10);

    // Back-to-back frames.
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    idle(3 * F + 10);

    // Overflow with a depth-4 FIFO.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i));
    idle(5 * F + 10);

    // Clear overflow, refill, then write on the last STOP cycle while full.
    step(1'b0, 8'h00);
    async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i));
    guard = 0;
    while (next_pop != edge_n + 1 && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    chk("pop_edge_found", 32'(guard < 200), 32'd1);
    chk("full_before_write", 32'(fifo_count), 32'(D));
    step(1'b1, 8'hEE);
    chk("count_after_full_write", 32'(fifo_count), 32'(D - 1));
    chk("overflow_after_full_write", 32'(overflow), 32'd1);
    idle(5 * F + 10);

    // Reset in the middle of DATA bit 3, then a clean frame.
    step(1'b1, 8'h5A);
    guard = 0;
    while (edge_n != cur_start + 4 * C + 1 && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    chk("mid_frame_reached", 32'(guard < 200), 32'd1);
    async_reset();
    idle(60);
    step(1'b1, 8'h3C);
    idle(F + 10);

    // Random traffic: sparse, then bursty enough to overflow.
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 49) == 0), 8'($urandom));
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 5) == 0), 8'($urandom));
    idle(6 * F + 10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
